// File: rtl/sync_rr_arbiter_pkg.sv
// Shared types and helpers for the clocked round-robin arbiter.
// Holds the state encoding, a one-hot builder and the hold-counter sizing rule.
package sync_rr_arbiter_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result is MAX_REQ wide; callers size-cast it down to their requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_REQ) begin
      v[idx[4:0]] = 1'b1;
    end
    return v;
  endfunction

  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold <= 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// wrapping past the top index back to 0.
module rr_priority_pick #(
  parameter int REQUESTORS = 8,
  parameter int IDX_W      = $clog2(REQUESTORS)
) (
  input  logic [REQUESTORS-1:0] request,
  input  logic [IDX_W-1:0]      ptr,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);

  localparam logic [IDX_W:0] REQ_W1 = (IDX_W+1)'(REQUESTORS);

  logic [IDX_W-1:0]      pos_arr [REQUESTORS];
  logic [REQUESTORS-1:0] rot_req;

  // rot_req[k] is the request of the requester k places after ptr.
  for (genvar gi = 0; gi < REQUESTORS; gi++) begin : g_rot
    wire [IDX_W:0] sum_w = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign pos_arr[gi] = IDX_W'((sum_w >= REQ_W1) ? (sum_w - REQ_W1) : sum_w);
    assign rot_req[gi] = request[pos_arr[gi]];
  end

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = REQUESTORS - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        idx   = pos_arr[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_rr_arbiter_sched.sv
// Clocked round-robin arbiter with grant locking, bounded hold time and a
// one-cycle break-before-make gap between successive owners.
module sync_rr_arbiter_sched
  import sync_rr_arbiter_pkg::*;
#(
  parameter  int REQUESTORS = 8,
  parameter  int MAX_HOLD   = 15,
  localparam int IDX_W      = $clog2(REQUESTORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [REQUESTORS-1:0] request,
  output logic [REQUESTORS-1:0] grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx
);

  localparam int HOLD_W = hold_cnt_w(MAX_HOLD);

  state_t                state_reg, state_next;
  logic [REQUESTORS-1:0] grant_reg, grant_next;
  logic                  grant_valid_reg, grant_valid_next;
  logic [IDX_W-1:0]      grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  take;
  logic                  release_now;

  rr_priority_pick #(
    .REQUESTORS (REQUESTORS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .request (request),
    .ptr     (ptr_reg),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign take = en && pick_found;

  // Owner lets go, or has used its last permitted cycle.
  assign release_now = !request[grant_idx_reg] ||
                       ((MAX_HOLD != 0) && (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      grant_idx_reg   <= '0;
      ptr_reg         <= '0;
      hold_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      grant_idx_reg   <= grant_idx_next;
      ptr_reg         <= ptr_next;
      hold_cnt_reg    <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = GRANT;
      GRANT:   if (release_now) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next       = grant_reg;
    grant_valid_next = grant_valid_reg;
    grant_idx_next   = grant_idx_reg;
    ptr_next         = ptr_reg;
    hold_cnt_next    = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          grant_next       = REQUESTORS'(onehot(int'(pick_idx), REQUESTORS));
          grant_valid_next = 1'b1;
          grant_idx_next   = pick_idx;
          hold_cnt_next    = '0;
          ptr_next         = (pick_idx == IDX_W'(REQUESTORS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_next       = '0;
          grant_valid_next = 1'b0;
        end else if (hold_cnt_reg != '1) begin
          // Saturates rather than wraps when hold time is unlimited.
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        grant_next       = '0;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_valid = grant_valid_reg;
  assign grant_idx   = grant_idx_reg;

endmodule

// File: tb/tb_sync_rr_arbiter_sched.sv
// Directed bench for sync_rr_arbiter_sched (8 requesters, hold limit 4).
// Outputs are sampled 1 time unit after each rising edge.
module tb_sync_rr_arbiter_sched;

  localparam int N  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_idx;

  int tests = 0;
  int fails = 0;

  sync_rr_arbiter_sched #(
    .REQUESTORS (N),
    .MAX_HOLD   (MH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic [2:0] ei);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|eg));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(ei));
    $display("[TB] %s: req=%02h en=%0b grant=%02h valid=%0b idx=%0d", tag, request, en,
             grant, grant_valid, grant_idx);
  endtask

  // Advance one edge and check outputs.
  task automatic step(input string tag, input logic [N-1:0] eg, input logic [2:0] ei);
    @(posedge clk);
    #1;
    chk_out(tag, eg, ei);
  endtask

  logic [N-1:0] pat_g [11];
  logic [2:0]   pat_i [11];

  initial begin
    pat_g = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02};
    pat_i = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

    // Reset without any clock edge
    rst_n   = 1'b1;
    en      = 1'b1;
    request = 8'hFF;
    #1 rst_n = 1'b0;
    #1 chk_out("rst_async", 8'h00, 3'd0);
    @(posedge clk); #1;
    chk_out("rst_held", 8'h00, 3'd0);
    rst_n = 1'b1;
    step("rst_first", 8'h01, 3'd0);

    // Reset asserted mid-grant clears the outputs immediately
    #2 rst_n = 1'b0;
    #1 chk_out("rst_mid", 8'h00, 3'd0);
    rst_n   = 1'b1;
    request = 8'h01;

    // Single owner holds while requesting, then releases
    step("one_a", 8'h01, 3'd0);
    step("one_b", 8'h01, 3'd0);
    step("one_c", 8'h01, 3'd0);
    request = 8'h00;
    step("one_drop", 8'h00, 3'd0);
    request = 8'h01;
    step("one_regrant", 8'h01, 3'd0);
    request = 8'h00;
    step("one_drop2", 8'h00, 3'd0);

    // Two contenders, timeout after 4 cycles, 1-cycle gap between owners
    request = 8'h03;
    for (int k = 0; k < 11; k++) begin
      step($sformatf("cont_%0d", k), pat_g[k], pat_i[k]);
    end
    request = 8'h00;
    step("cont_drop", 8'h00, 3'd1);

    // Rotation and skip (pointer now at 2)
    request = 8'h30;
    step("rot_skip", 8'h10, 3'd4);
    request = 8'h00;
    step("rot_rel", 8'h00, 3'd4);
    request = 8'h31;
    step("rot_next", 8'h20, 3'd5);
    request = 8'h00;
    step("rot_rel2", 8'h00, 3'd5);
    request = 8'h80;
    step("own7", 8'h80, 3'd7);
    request = 8'h00;
    step("own7_rel", 8'h00, 3'd7);

    // Wrap: pointer back at 0, requester 7 wins after 0 times out
    request = 8'h81;
    step("wrap_0", 8'h01, 3'd0);
    step("wrap_1", 8'h01, 3'd0);
    step("wrap_2", 8'h01, 3'd0);
    step("wrap_3", 8'h01, 3'd0);
    step("wrap_gap", 8'h00, 3'd0);
    step("wrap_7", 8'h80, 3'd7);

    // Lone requester is re-granted after the gap following timeout
    request = 8'h08;
    step("lone_rel7", 8'h00, 3'd7);
    step("lone_a", 8'h08, 3'd3);
    step("lone_b", 8'h08, 3'd3);
    step("lone_c", 8'h08, 3'd3);
    step("lone_d", 8'h08, 3'd3);
    step("lone_gap", 8'h00, 3'd3);
    step("lone_again", 8'h08, 3'd3);
    request = 8'h00;
    step("lone_drop", 8'h00, 3'd3);

    // Enable gating
    en      = 1'b0;
    request = 8'h04;
    for (int k = 0; k < 5; k++) begin
      step($sformatf("en_off_%0d", k), 8'h00, 3'd3);
    end
    en = 1'b1;
    step("en_on", 8'h04, 3'd2);
    en = 1'b0;
    step("en_drop_a", 8'h04, 3'd2);
    step("en_drop_b", 8'h04, 3'd2);
    step("en_drop_c", 8'h04, 3'd2);
    step("en_timeout", 8'h00, 3'd2);
    step("en_idle", 8'h00, 3'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
